// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, FSM states
// and the default bus address width.
package spi_pkg;

    // 128 KB memory window; bit 16 of the address comes from the command byte
    localparam int DEF_ADDR_WIDTH = 17;

    // Command opcode, taken from bits [7:6] of the command byte
    typedef logic [1:0] op_t;

    localparam op_t OP_WRITE      = 2'b00;
    localparam op_t OP_READ       = 2'b01;
    localparam op_t OP_WRITE_NEXT = 2'b10;
    localparam op_t OP_READ_NEXT  = 2'b11;

    // Frame parser states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_REQ
    } state_t;

endpackage

// File: rtl/sync2_edge.sv
// N-stage synchronizer for an asynchronous level, with single-cycle
// rising and falling edge pulses derived from the synchronized level.
module sync2_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the async input through the synchronizer chain and remember the last synchronized level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Edge pulses last exactly one cycle, the cycle after the synchronized level changes
    always_comb begin
        sync_out = sync_q[STAGES-1];
        rise     = sync_q[STAGES-1] & ~prev_q;
        fall     = ~sync_q[STAGES-1] & prev_q;
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns the byte stream from spi_slave into single-byte request/acknowledge
// memory accesses in the sys_clk domain. Parses command frames, keeps an
// auto-incrementing address for streaming access and returns read data on
// spi_tx for the next SPI reply byte.
module spi_cmd_decoder
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  spi_cs_n,
    input  logic [7:0]            spi_rx,
    input  logic                  spi_done,
    output logic                  bus_req,
    output logic                  bus_rw_n,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wr_data,
    input  logic                  bus_ack,
    input  logic [7:0]            bus_rd_data,
    output logic [7:0]            spi_tx,
    output logic                  overrun
);

    state_t                state;
    state_t                state_next;
    op_t                   cmd_op;
    logic                  cmd_a16;
    logic                  done_rise;
    logic                  done_level_unused;
    logic                  done_fall_unused;
    logic                  cs_sync;
    logic                  cs_rise;
    logic                  cs_fall;
    logic                  byte_valid;
    logic                  access_done;
    logic [ADDR_WIDTH-1:0] addr_hi_load;

    sync2_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_done_sync (
        .clk      (sys_clk),
        .rst_n    (reset_n),
        .async_in (spi_done),
        .sync_out (done_level_unused),
        .rise     (done_rise),
        .fall     (done_fall_unused)
    );

    sync2_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk      (sys_clk),
        .rst_n    (reset_n),
        .async_in (spi_cs_n),
        .sync_out (cs_sync),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // A byte counts only while chip select is active; the access finishes on the acknowledged REQ cycle
    always_comb begin
        byte_valid  = done_rise & ~cs_sync;
        access_done = (state == ST_REQ) & bus_ack;
    end

    // Address as it looks after loading the high byte: A16 from the command, bits [15:8] from the wire
    always_comb begin
        addr_hi_load       = bus_addr;
        addr_hi_load[16]   = cmd_a16;
        addr_hi_load[15:8] = spi_rx;
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: walk the frame byte by byte; chip select rising drops a partial frame but never a pending access
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (byte_valid) begin
                    case (op_t'(spi_rx[7:6]))
                        OP_READ_NEXT: state_next = ST_REQ;
                        OP_READ:      state_next = ST_ADDR_HI;
                        default:      state_next = ST_DATA;
                    endcase
                end
            end
            ST_DATA: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (byte_valid) begin
                    state_next = (cmd_op == OP_WRITE) ? ST_ADDR_HI : ST_REQ;
                end
            end
            ST_ADDR_HI: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (byte_valid) begin
                    state_next = ST_ADDR_LO;
                end
            end
            ST_ADDR_LO: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (byte_valid) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: the request is held for as long as the FSM sits in REQ
    always_comb begin
        bus_req = (state == ST_REQ);
    end

    // Datapath: capture frame fields as bytes arrive, then bump the address and catch read data on the acknowledge
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_op      <= OP_WRITE;
            cmd_a16     <= 1'b0;
            bus_rw_n    <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= 8'h00;
            spi_tx      <= 8'h00;
        end else begin
            if (byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        cmd_op   <= op_t'(spi_rx[7:6]);
                        cmd_a16  <= spi_rx[0];
                        bus_rw_n <= spi_rx[6];
                    end
                    ST_DATA:    bus_wr_data   <= spi_rx;
                    ST_ADDR_HI: bus_addr      <= addr_hi_load;
                    ST_ADDR_LO: bus_addr[7:0] <= spi_rx;
                    default: ;
                endcase
            end
            if (access_done) begin
                bus_addr <= bus_addr + ADDR_WIDTH'(1);
                if (bus_rw_n) begin
                    spi_tx <= bus_rd_data;
                end
            end
        end
    end

    // Sticky overrun: a byte landing while an access is still pending is lost; cleared when a new frame starts
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (cs_fall) begin
            overrun <= 1'b0;
        end else if (byte_valid && (state == ST_REQ)) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: frames are built from randomized
// commands, a frame-level memory model predicts every bus access, and a
// monitor compares each acknowledged access and its after-effects.
module tb_spi_cmd_decoder;
    import spi_pkg::*;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic [7:0]  spi_rx = 8'h00;
    logic        spi_done = 1'b0;
    logic        bus_req;
    logic        bus_rw_n;
    logic [16:0] bus_addr;
    logic [7:0]  bus_wr_data;
    logic        bus_ack = 1'b0;
    logic [7:0]  bus_rd_data = 8'h00;
    logic [7:0]  spi_tx;
    logic        overrun;

    typedef struct {
        logic        rw_n;
        logic [16:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  tx;
    } exp_t;

    exp_t        expQ[$];
    exp_t        pend;
    exp_t        monE;
    bit          pendValid = 1'b0;
    int          vecCount = 0;
    int          errCount = 0;
    logic [16:0] mAddr = 17'h0;
    logic [7:0]  mTx = 8'h00;
    logic [7:0]  modelMem[int];
    logic [7:0]  respMem[int];
    bit          holdAck = 1'b0;
    int          reqCount = 0;
    logic        reqPrev = 1'b0;

    spi_cmd_decoder #(
        .ADDR_WIDTH  (17),
        .SYNC_STAGES (2)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .spi_cs_n    (spi_cs_n),
        .spi_rx      (spi_rx),
        .spi_done    (spi_done),
        .bus_req     (bus_req),
        .bus_rw_n    (bus_rw_n),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_ack     (bus_ack),
        .bus_rd_data (bus_rd_data),
        .spi_tx      (spi_tx),
        .overrun     (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    // Power-on contents of the memory behind the bus
    function automatic logic [7:0] initByte(input int a);
        return 8'((a * 13 + 7) ^ (a >> 8));
    endfunction

    function automatic logic [7:0] modelRead(input int a);
        if (modelMem.exists(a)) return modelMem[a];
        return initByte(a);
    endfunction

    function automatic logic [7:0] respRead(input int a);
        if (respMem.exists(a)) return respMem[a];
        return initByte(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportFail(input string name);
        vecCount++;
        errCount++;
        $display("[TB] FAIL %s: got no/unexpected event, expected a clean handshake at %0t", name, $time);
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge sys_clk);
        spi_rx   = b;
        spi_done = 1'b1;
        repeat (4) @(negedge sys_clk);
        spi_done = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic startFrame();
        @(negedge sys_clk);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic endFrame();
        @(negedge sys_clk);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge sys_clk);
    endtask

    // Send one frame and predict its access from the frame rules
    task automatic applyStimulus(input logic [1:0] op, input logic [16:0] addr, input logic [7:0] data);
        exp_t       e;
        logic [7:0] cmd;
        cmd = {op, 5'($urandom), (op[1] ? 1'($urandom) : addr[16])};
        if (op == OP_WRITE || op == OP_READ) mAddr = addr;
        e.rw_n  = op[0];
        e.addr  = mAddr;
        e.wdata = data;
        if (op[0]) mTx = modelRead(int'(mAddr));
        else modelMem[int'(mAddr)] = data;
        e.tx = mTx;
        expQ.push_back(e);
        mAddr = mAddr + 17'd1;
        sendByte(cmd);
        case (op)
            OP_WRITE: begin
                sendByte(data);
                sendByte(addr[15:8]);
                sendByte(addr[7:0]);
            end
            OP_READ: begin
                sendByte(addr[15:8]);
                sendByte(addr[7:0]);
            end
            OP_WRITE_NEXT: sendByte(data);
            default: ;
        endcase
    endtask

    task automatic waitAccessDone();
        bit seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge sys_clk);
            if (!bus_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) reportFail("access_timeout");
        @(negedge sys_clk);
    endtask

    // Bus slave: memory with a random acknowledge latency
    initial begin
        int ackDelay = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (bus_ack) begin
                bus_ack     = 1'b0;
                bus_rd_data = 8'($urandom);
                ackDelay    = $urandom_range(0, 3);
            end else if (bus_req && reset_n && !holdAck) begin
                if (ackDelay > 0) begin
                    ackDelay--;
                end else begin
                    bus_ack = 1'b1;
                    if (bus_rw_n) bus_rd_data = respRead(int'(bus_addr));
                    else respMem[int'(bus_addr)] = bus_wr_data;
                end
            end else begin
                bus_rd_data = 8'($urandom);
            end
        end
    end

    // Monitor: compare every acknowledged access against the scoreboard queue
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!reset_n) begin
                reqPrev   = 1'b0;
                pendValid = 1'b0;
            end else begin
                if (bus_req && !reqPrev) reqCount++;
                reqPrev = bus_req;
                if (pendValid) begin
                    checkOutput("spi_tx", 32'(spi_tx), 32'(pend.tx));
                    checkOutput("addr_post_inc", 32'(bus_addr), 32'(17'(pend.addr + 17'd1)));
                    pendValid = 1'b0;
                end
                if (bus_req && bus_ack) begin
                    if (expQ.size() == 0) begin
                        reportFail("unexpected_access");
                    end else begin
                        monE = expQ.pop_front();
                        checkOutput("bus_rw_n", 32'(bus_rw_n), 32'(monE.rw_n));
                        checkOutput("bus_addr", 32'(bus_addr), 32'(monE.addr));
                        if (!monE.rw_n) checkOutput("bus_wr_data", 32'(bus_wr_data), 32'(monE.wdata));
                        pend      = monE;
                        pendValid = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0;
        int nFrames;
        logic [16:0] ra;

        repeat (3) @(negedge sys_clk);
        checkOutput("rst_bus_req", 32'(bus_req), 32'h0);
        checkOutput("rst_bus_rw_n", 32'(bus_rw_n), 32'h1);
        checkOutput("rst_bus_addr", 32'(bus_addr), 32'h0);
        checkOutput("rst_bus_wr_data", 32'(bus_wr_data), 32'h0);
        checkOutput("rst_spi_tx", 32'(spi_tx), 32'h0);
        checkOutput("rst_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        $display("[TB] write frame");
        startFrame();
        applyStimulus(OP_WRITE, 17'h11234, 8'hA5);
        waitAccessDone();
        checkOutput("write_addr_after", 32'(bus_addr), 32'h11235);

        $display("[TB] read then read-next");
        respMem[32'h08000] = 8'h5C;  modelMem[32'h08000] = 8'h5C;
        respMem[32'h08001] = 8'h7E;  modelMem[32'h08001] = 8'h7E;
        applyStimulus(OP_READ, 17'h08000, 8'h00);
        waitAccessDone();
        checkOutput("read_tx", 32'(spi_tx), 32'h5C);
        applyStimulus(OP_READ_NEXT, 17'h0, 8'h00);
        waitAccessDone();
        checkOutput("read_next_tx", 32'(spi_tx), 32'h7E);
        endFrame();

        $display("[TB] address wrap");
        startFrame();
        applyStimulus(OP_WRITE, 17'h1FFFF, 8'h3C);
        waitAccessDone();
        checkOutput("wrap_addr", 32'(bus_addr), 32'h0);
        applyStimulus(OP_WRITE_NEXT, 17'h0, 8'h99);
        waitAccessDone();
        endFrame();

        $display("[TB] overrun");
        startFrame();
        holdAck = 1'b1;
        applyStimulus(OP_READ, 17'h0A0F0, 8'h00);
        checkOutput("req_held", 32'(bus_req), 32'h1);
        sendByte(8'h55);
        checkOutput("overrun_set", 32'(overrun), 32'h1);
        checkOutput("req_after_overrun", 32'(bus_req), 32'h1);
        holdAck = 1'b0;
        waitAccessDone();
        applyStimulus(OP_READ_NEXT, 17'h0, 8'h00);
        waitAccessDone();
        checkOutput("overrun_sticky", 32'(overrun), 32'h1);
        endFrame();
        startFrame();
        checkOutput("overrun_cleared", 32'(overrun), 32'h0);
        endFrame();

        $display("[TB] abort partial frame");
        startFrame();
        r0 = reqCount;
        sendByte(8'h01);
        sendByte(8'hA5);
        endFrame();
        repeat (4) @(negedge sys_clk);
        checkOutput("abort_no_req", 32'(reqCount - r0), 32'h0);
        startFrame();
        applyStimulus(OP_WRITE, 17'h00ABC, 8'h3D);
        waitAccessDone();
        endFrame();

        $display("[TB] reset during request");
        startFrame();
        holdAck = 1'b1;
        applyStimulus(OP_WRITE, 17'h15555, 8'hE7);
        sendByte(8'h40);
        checkOutput("req_before_reset", 32'(bus_req), 32'h1);
        @(posedge sys_clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_bus_req", 32'(bus_req), 32'h0);
        checkOutput("async_rst_bus_rw_n", 32'(bus_rw_n), 32'h1);
        checkOutput("async_rst_bus_addr", 32'(bus_addr), 32'h0);
        checkOutput("async_rst_bus_wr_data", 32'(bus_wr_data), 32'h0);
        checkOutput("async_rst_spi_tx", 32'(spi_tx), 32'h0);
        checkOutput("async_rst_overrun", 32'(overrun), 32'h0);
        expQ.delete();
        mAddr   = 17'h0;
        mTx     = 8'h00;
        holdAck = 1'b0;
        @(negedge sys_clk);
        reset_n = 1'b1;
        endFrame();

        $display("[TB] randomized frames");
        for (int w = 0; w < 40; w++) begin
            startFrame();
            nFrames = $urandom_range(1, 4);
            for (int f = 0; f < nFrames; f++) begin
                ra = 17'($urandom);
                if ($urandom_range(0, 4) == 0) ra = 17'h1FFFF - 17'($urandom_range(0, 1));
                applyStimulus(2'($urandom_range(0, 3)), ra, 8'($urandom));
                waitAccessDone();
            end
            endFrame();
        end

        repeat (4) @(negedge sys_clk);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
